// File: rtl/neuron_layer_sequencer.sv
// Sequences one layer pass over a shared 4-input neuron: issues every row of the
// weight table, captures the results, then streams them out with valid/ready.
module neuron_layer_sequencer #(
   parameter int NUM_OUT = 4,
   parameter int IDX_W   = $clog2(NUM_OUT)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_addr,
   input  logic [19:0]              cfg_wdata,
   input  logic                     start,
   input  logic signed [11:0]       x0,
   input  logic signed [11:0]       x1,
   input  logic signed [11:0]       x2,
   input  logic signed [11:0]       x3,
   output logic                     busy,
   output logic                     done,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_idx,
   output logic signed [16:0]       out_data,
   output logic                     nrn_input_ready,
   output logic signed [11:0]       nrn_in0,
   output logic signed [11:0]       nrn_in1,
   output logic signed [11:0]       nrn_in2,
   output logic signed [11:0]       nrn_in3,
   output logic signed [4:0]        nrn_w0,
   output logic signed [4:0]        nrn_w1,
   output logic signed [4:0]        nrn_w2,
   output logic signed [4:0]        nrn_w3,
   input  logic                     nrn_result_ready,
   input  logic signed [16:0]       nrn_result
);

   // Storage spans the full index range so any IDX_W-wide index stays in bounds.
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       iss_cnt_q, cap_cnt_q, rd_cnt_q;
   logic                   done_q;
   logic [19:0]            wt_q  [DEPTH];
   logic signed [16:0]     buf_q [DEPTH];
   logic signed [11:0]     x_q   [4];

   logic                   cfg_hit, is_iss, is_out, capture;
   logic [19:0]            w_sel;

   assign cfg_hit = (IDX_W+1)'(cfg_addr) < (IDX_W+1)'(NUM_OUT);
   assign is_iss  = (state_q == ISSUE);
   assign is_out  = (state_q == OUTPUT);
   assign capture = nrn_result_ready && (state_q == ISSUE || state_q == DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         iss_cnt_q <= '0;
         cap_cnt_q <= '0;
         rd_cnt_q  <= '0;
         done_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            wt_q[i]  <= '0;
            buf_q[i] <= '0;
         end
         for (int k = 0; k < 4; k++) x_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_we && cfg_hit) wt_q[cfg_addr] <= cfg_wdata;
               if (start) begin
                  x_q[0]    <= x0;
                  x_q[1]    <= x1;
                  x_q[2]    <= x2;
                  x_q[3]    <= x3;
                  iss_cnt_q <= '0;
                  cap_cnt_q <= '0;
                  rd_cnt_q  <= '0;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               iss_cnt_q <= iss_cnt_q + 1'b1;
               if (iss_cnt_q == LAST) state_q <= DRAIN;
            end
            // The neuron answers one cycle after each issue, so the last result lands here.
            DRAIN: if (nrn_result_ready && cap_cnt_q == LAST) state_q <= OUTPUT;
            OUTPUT: begin
               if (out_ready) begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
                  if (rd_cnt_q == LAST) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         if (capture) begin
            buf_q[cap_cnt_q] <= nrn_result;
            cap_cnt_q        <= cap_cnt_q + 1'b1;
         end
      end
   end

   assign w_sel           = is_iss ? wt_q[iss_cnt_q] : '0;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign nrn_input_ready = is_iss;
   assign nrn_in0         = is_iss ? x_q[0] : '0;
   assign nrn_in1         = is_iss ? x_q[1] : '0;
   assign nrn_in2         = is_iss ? x_q[2] : '0;
   assign nrn_in3         = is_iss ? x_q[3] : '0;
   assign nrn_w0          = w_sel[4:0];
   assign nrn_w1          = w_sel[9:5];
   assign nrn_w2          = w_sel[14:10];
   assign nrn_w3          = w_sel[19:15];
   assign out_valid       = is_out;
   assign out_idx         = is_out ? rd_cnt_q : '0;
   assign out_data        = is_out ? buf_q[rd_cnt_q] : '0;

endmodule

// File: doc/neuron_layer_sequencer.md
NEURON_LAYER_SEQUENCER -- requirements
Module: neuron_layer_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_OUT, default 4, meaning the number of output neurons sequenced per layer pass (legal range 2..16).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_OUT), meaning the width of the neuron index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 cfg_we  input  1  weight-table write strobe.
REQ-006 cfg_addr  input  IDX_W  neuron index written.
REQ-007 cfg_wdata  input  20  four signed 5-bit weights; w0=[4:0], w1=[9:5], w2=[14:10], w3=[19:15].
REQ-008 start  input  1  begin a layer pass using x0..x3.
REQ-009 x0, x1, x2, x3  input  12 each, signed  input activations.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse when the pass completes.
REQ-012 out_valid  output  1  a result is presented.
REQ-013 out_ready  input  1  consumer accepts the presented result.
REQ-014 out_idx  output  IDX_W  neuron index of out_data.
REQ-015 out_data  output  17, signed  neuron result.
REQ-016 nrn_input_ready  output  1  issue strobe to the shared 4-input neuron.
REQ-017 nrn_in0..nrn_in3  output  12 each, signed  activations to the neuron.
REQ-018 nrn_w0..nrn_w3  output  5 each, signed  weights to the neuron.
REQ-019 nrn_result_ready  input  1  neuron result valid; arrives exactly 1 cycle after the issue.
REQ-020 nrn_result  input  17, signed  neuron result.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, DRAIN and OUTPUT.
REQ-022 In IDLE with start=1, the block SHALL latch x0..x3, clear issue/capture/read counters and enter ISSUE next cycle; start outside IDLE SHALL be ignored.
REQ-023 In ISSUE: nrn_input_ready=1, nrn_in* = latched x, nrn_w* = weight table[issue_cnt]; issue_cnt increments every cycle; at issue_cnt==NUM_OUT-1 the next state SHALL be DRAIN.
REQ-024 Outside ISSUE, nrn_input_ready, nrn_in* and nrn_w* SHALL be 0.
REQ-025 In ISSUE or DRAIN, nrn_result_ready=1 SHALL write nrn_result to result buffer[cap_cnt] and increment cap_cnt; nrn_result_ready in IDLE or OUTPUT SHALL be ignored.
REQ-026 DRAIN SHALL go to OUTPUT in the cycle after the capture of entry NUM_OUT-1; start-to-OUTPUT latency is NUM_OUT+2 cycles.
REQ-027 In OUTPUT: out_valid=1, out_idx=rd_cnt, out_data=buffer[rd_cnt]; out_valid&&out_ready advances rd_cnt; out_idx/out_data SHALL hold stable while out_ready=0.
REQ-028 The transfer of index NUM_OUT-1 SHALL return the FSM to IDLE and assert done for exactly the following cycle; start in that done cycle SHALL be accepted.
REQ-029 cfg_we SHALL write the weight table only in IDLE and only when cfg_addr<NUM_OUT; otherwise the write is dropped.
REQ-030 The block SHALL perform no arithmetic on results; out_data equals the captured nrn_result bit-exact.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, zero all counters, the weight table and the result buffer, and drive busy, done, out_valid, out_idx, out_data, nrn_* to 0 from the next cycle.
REQ-032 Reset in any state SHALL abort the pass with no done pulse and no out_valid.

Verification
REQ-033 Load table rows 0..3 with all-weights 1, 2, -1, 0; start with x=(1,2,3,4); neuron model attached -> out_data sequence 10, 20, -10, 0 at out_idx 0..3, done pulsed once, busy high from cycle after start until done.
REQ-034 x=(100,100,100,100), row 0 weights all -3 -> out_idx 0 out_data -1200.
REQ-035 Hold out_ready=0 for 5 cycles in OUTPUT -> out_valid stays 1 with out_idx 0 and unchanged data; then out_ready=1 -> one transfer per cycle, done after the 4th.
REQ-036 cfg_we to row 1 and start pulses while busy -> table unchanged, pass unaffected, no second pass.
REQ-037 rst_n=0 during ISSUE at issue_cnt=2 -> next cycle busy=0, nrn_input_ready=0, no done, no out_valid; weight table reads 0.
REQ-038 cfg_addr=NUM_OUT with cfg_we=1 -> no row modified.
